serialtx_arbiter: RTL

Round-robin arbiter that shares one Wishbone-attached UART transmitter (`serialtx` slave port: write-only byte sink, asserts `wb_stall` while a frame is in flight, single registered `wb_ack` per accepted strobe) among `NREQ` byte-stream requesters. It sits between on-chip producers (debug, logging, command responders) and the UART, owning the Wishbone master side. It latches one byte at a time, runs a single-beat Wishbone write, and guards against a missing acknowledge with a timeout.

---
 rtl/serialtx_arbiter_if.sv | 28 ++
 rtl/serialtx_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/serialtx_arbiter_if.sv
// serialtx_arbiter_if: requester streams and Wishbone master bundle of the UART arbiter
interface serialtx_arbiter_if #(
  parameter int NREQ = 3,
  parameter int FRAME = 8
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*FRAME-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [31:0] wb_addr;
  logic [FRAME-1:0] wb_data_w;
  logic wb_we;
  logic wb_stb;
  logic wb_cyc;
  logic wb_stall;
  logic wb_ack;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic [31:0] sent_count;
  logic timeout_err;
  modport master (
    input req_valid, req_data, req_last, wb_stall, wb_ack,
    output req_ready, wb_addr, wb_data_w, wb_we, wb_stb, wb_cyc, grant_id, sent_count, timeout_err
  );
  modport slave (
    output req_valid, req_data, req_last, wb_stall, wb_ack,
    input req_ready, wb_addr, wb_data_w, wb_we, wb_stb, wb_cyc, grant_id, sent_count, timeout_err
  );
endinterface

// File: rtl/serialtx_arbiter.sv
// serialtx_arbiter: round-robin share of one Wishbone UART transmitter; SERIALTX_ARB_LOCK_EN adds packet lock
module serialtx_arbiter #(
  parameter int NREQ = 3,
  parameter int FRAME = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter logic [31:0] TX_ADDR = 32'h0
) (
  input logic clk,
  input logic rst_n,
  serialtx_arbiter_if.master bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW = $clog2(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK} state_t;
  state_t state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic win_ok;
  logic win_last;
  logic [FRAME-1:0] win_byte;
  logic [NREQ-1:0] elig;
  logic [CW-1:0] cnt;
`ifdef SERIALTX_ARB_LOCK_EN
  logic lock_on;
  logic [IDW-1:0] lock_id;
  assign elig = lock_on ? bus.req_valid & (NREQ'(1) << lock_id) : bus.req_valid;
`else
  logic unused_last;
  assign unused_last = win_last;
  assign elig = bus.req_valid;
`endif
  assign bus.wb_addr = TX_ADDR;
  assign bus.req_ready = (state == IDLE && win_ok) ? NREQ'(1) << win : '0;
  // pick the eligible requester closest after ptr; descending k lets the nearest one overwrite
  always_comb begin
    win = ptr;
    win_ok = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      for (int j = 0; j < NREQ; j++)
        if (elig[j] && (int'(ptr) + k) % NREQ == j) begin
          win = IDW'(j);
          win_ok = 1'b1;
        end
    win_byte = '0;
    win_last = 1'b0;
    for (int j = 0; j < NREQ; j++)
      if (IDW'(j) == win) begin
        win_byte = bus.req_data[j*FRAME +: FRAME];
        win_last = bus.req_last[j];
      end
  end
  // grant, single-beat write, ack wait with timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= IDW'(NREQ - 1);
      cnt <= '0;
      bus.grant_id <= '0;
      bus.wb_data_w <= '0;
      bus.wb_cyc <= 1'b0;
      bus.wb_stb <= 1'b0;
      bus.wb_we <= 1'b0;
      bus.sent_count <= '0;
      bus.timeout_err <= 1'b0;
`ifdef SERIALTX_ARB_LOCK_EN
      lock_on <= 1'b0;
      lock_id <= '0;
`endif
    end else case (state)
      IDLE: if (win_ok) begin
        state <= STROBE;
        ptr <= win;
        bus.grant_id <= win;
        bus.wb_data_w <= win_byte;
        bus.wb_cyc <= 1'b1;
        bus.wb_stb <= 1'b1;
        bus.wb_we <= 1'b1;
`ifdef SERIALTX_ARB_LOCK_EN
        lock_on <= !win_last;
        lock_id <= win;
`endif
      end
      STROBE: if (!bus.wb_stall) begin
        state <= WAIT_ACK;
        cnt <= '0;
        bus.wb_stb <= 1'b0;
        bus.wb_we <= 1'b0;
      end
      WAIT_ACK: if (bus.wb_ack) begin
        state <= IDLE;
        bus.wb_cyc <= 1'b0;
        bus.sent_count <= bus.sent_count + 32'd1;
      end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
        state <= IDLE;
        bus.wb_cyc <= 1'b0;
        bus.timeout_err <= 1'b1;
`ifdef SERIALTX_ARB_LOCK_EN
        lock_on <= 1'b0;
`endif
      end else cnt <= cnt + 1'b1;
      default: state <= IDLE;
    endcase
endmodule
